// File: rtl/modem_ctrl.sv
// rtl/modem_ctrl.sv - UART modem-line controller: MSR status/deltas, filtered inputs, auto-RTS, loopback, CTS-gated TX grant
// Lines are indexed 0=cts, 1=dsr, 2=ri, 3=dcd throughout.
module modem_ctrl #(
  parameter int FILT_CYCLES = 4,
  parameter int FIFO_AW     = 4,
  parameter int RX_HI       = 14,
  parameter int RX_LO       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cts_pad_i,
  input  logic               dsr_pad_i,
  input  logic               ri_pad_i,
  input  logic               dcd_pad_i,
  output logic               rts_pad_o,
  output logic               dtr_pad_o,
  input  logic [4:0]         mcr_i,
  input  logic               afe_en_i,
  input  logic               ier_ms_i,
  input  logic               msr_rd_i,
  output logic [7:0]         msr_o,
  output logic               msi_o,
  input  logic [FIFO_AW:0]   rx_level_i,
  input  logic               tx_req_i,
  output logic               tx_gnt_o
);

  typedef enum logic {RTS_ON = 1'b0, RTS_OFF = 1'b1} rts_state_t;

  localparam logic [3:0]       LP_FMAX = 4'(FILT_CYCLES - 1);
  localparam logic [FIFO_AW:0] LP_HI   = (FIFO_AW + 1)'(RX_HI);
  localparam logic [FIFO_AW:0] LP_LO   = (FIFO_AW + 1)'(RX_LO);

  if (!(RX_LO < RX_HI && RX_HI <= 2 ** FIFO_AW)) begin : g_bad_levels
    $error("modem_ctrl: need RX_LO < RX_HI <= 2**FIFO_AW");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_bad_filt
    $error("modem_ctrl: FILT_CYCLES must be 1..15");
  end

  logic [3:0] r_sync1, r_sync2, r_filt, r_delta;
  logic [3:0] r_cnt [4];
  logic       r_msi, r_rts, r_dtr, r_gnt;
  rts_state_t r_state, w_state_nxt;
  logic [3:0] w_pads, w_src, w_tog, w_set;
  logic       w_loop;

  assign w_loop = mcr_i[4];
  assign w_pads = {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
  // Loopback feeds the filter directly, bypassing the synchroniser.
  assign w_src  = w_loop ? {mcr_i[3], mcr_i[2], mcr_i[0], mcr_i[1]} : r_sync2;

  always_comb begin
    w_tog = '0;
    for (int i = 0; i < 4; i++) begin
      w_tog[i] = (w_src[i] != r_filt[i]) && (r_cnt[i] == LP_FMAX);
    end
  end

  // Trailing-edge ring indicator: only a filtered ri 1->0 raises teri.
  assign w_set = {w_tog[3], w_tog[2] & r_filt[2], w_tog[1], w_tog[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pads;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_src[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tog[i]) begin
          r_cnt[i]  <= '0;
          r_filt[i] <= ~r_filt[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delta <= '0;
      r_msi   <= 1'b0;
    end else begin
      r_delta <= w_set | (r_delta & ~{4{msr_rd_i}});
      r_msi   <= ier_ms_i & (|r_delta);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RTS_ON:  if (afe_en_i && rx_level_i >= LP_HI) w_state_nxt = RTS_OFF;
      RTS_OFF: if (!afe_en_i || rx_level_i <= LP_LO) w_state_nxt = RTS_ON;
      default: w_state_nxt = RTS_ON;
    endcase
  end

  // Pads follow the next state so a level change shows one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RTS_ON;
      r_rts   <= 1'b0;
      r_dtr   <= 1'b0;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rts   <= mcr_i[1] & (w_state_nxt == RTS_ON) & ~w_loop;
      r_dtr   <= mcr_i[0] & ~w_loop;
      r_gnt   <= tx_req_i & ~r_gnt & (~afe_en_i | r_filt[0]);
    end
  end

  assign msr_o     = {r_filt, r_delta};
  assign msi_o     = r_msi;
  assign rts_pad_o = r_rts;
  assign dtr_pad_o = r_dtr;
  assign tx_gnt_o  = r_gnt;

endmodule

// File: tb/tb_modem_ctrl.sv
// tb/tb_modem_ctrl.sv - randomized and directed bench for modem_ctrl against a behavioural model
module tb_modem_ctrl;
  localparam int FC = 4;
  localparam int AW = 4;
  localparam int HI = 14;
  localparam int LO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cts, dsr, ri, dcd, afe, ier, rd, req;
  logic [4:0] mcr;
  logic [AW:0] lvl;
  logic rts_o, dtr_o, msi_o, gnt_o;
  logic [7:0] msr_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: sync pipeline, last FC filter samples, filtered lines, deltas, outputs.
  logic [3:0] m_s1, m_s2, m_filt, m_delta;
  logic [3:0] m_hist [FC];
  logic       m_msi, m_rts_on, m_rts, m_dtr, m_gnt;

  modem_ctrl #(.FILT_CYCLES(FC), .FIFO_AW(AW), .RX_HI(HI), .RX_LO(LO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cts_pad_i(cts), .dsr_pad_i(dsr), .ri_pad_i(ri), .dcd_pad_i(dcd),
    .rts_pad_o(rts_o), .dtr_pad_o(dtr_o),
    .mcr_i(mcr), .afe_en_i(afe), .ier_ms_i(ier), .msr_rd_i(rd),
    .msr_o(msr_o), .msi_o(msi_o),
    .rx_level_i(lvl), .tx_req_i(req), .tx_gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_delta = '0;
    for (int k = 0; k < FC; k++) m_hist[k] = '0;
    m_msi = 0; m_rts_on = 1; m_rts = 0; m_dtr = 0; m_gnt = 0;
  endtask

  task automatic model_step();
    logic [3:0] src, tog, set;
    logic all_diff;
    src = mcr[4] ? {mcr[3], mcr[2], mcr[0], mcr[1]} : m_s2;
    for (int k = FC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = src;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1;
      for (int k = 0; k < FC; k++) if (m_hist[k][i] == m_filt[i]) all_diff = 0;
      tog[i] = all_diff;
    end
    m_msi = ier & (m_delta != 0);
    m_gnt = req & !m_gnt & (!afe | m_filt[0]);
    set = {tog[3], tog[2] & m_filt[2], tog[1], tog[0]};
    m_delta = set | (rd ? 4'b0 : m_delta);
    m_filt = m_filt ^ tog;
    m_s2 = m_s1;
    m_s1 = {dcd, ri, dsr, cts};
    if (m_rts_on) m_rts_on = !(afe && int'(lvl) >= HI);
    else          m_rts_on = !afe || int'(lvl) <= LO;
    m_rts = mcr[1] & m_rts_on & !mcr[4];
    m_dtr = mcr[0] & !mcr[4];
  endtask

  task automatic compare();
    chk("msr", msr_o, {m_filt, m_delta});
    chk("msi", 8'(msi_o), 8'(m_msi));
    chk("rts", 8'(rts_o), 8'(m_rts));
    chk("dtr", 8'(dtr_o), 8'(m_dtr));
    chk("gnt", 8'(gnt_o), 8'(m_gnt));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    cts = 0; dsr = 0; ri = 0; dcd = 0; afe = 0; ier = 0; rd = 0; req = 0;
    mcr = '0; lvl = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic mid_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_msr", msr_o, 8'h00);
    chk("rst_msi", 8'(msi_o), 8'h00);
    chk("rst_rts", 8'(rts_o), 8'h00);
    chk("rst_dtr", 8'(dtr_o), 8'h00);
    chk("rst_gnt", 8'(gnt_o), 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    compare();
    do_reset();
    compare();

    // CTS edge latency, interrupt, read-clear
    ier = 1; cts = 1;
    repeat (5) tick();
    chk("cts_before", msr_o, 8'h00);
    tick();
    chk("cts_edge6", msr_o, 8'h11);
    chk("msi_lag", 8'(msi_o), 8'h00);
    tick();
    chk("msi_set", 8'(msi_o), 8'h01);
    rd = 1; tick(); rd = 0;
    chk("dcts_clr", msr_o, 8'h10);
    tick();
    chk("msi_clr", 8'(msi_o), 8'h00);

    // Glitch rejection then a real DCD pulse
    do_reset();
    dcd = 1; repeat (3) tick();
    dcd = 0; repeat (8) tick();
    chk("glitch", msr_o, 8'h00);
    dcd = 1; repeat (6) tick();
    chk("dcd_set", msr_o, 8'h88);

    // RI trailing edge and set-wins-over-read
    do_reset();
    ri = 1; repeat (6) tick();
    chk("ri_rise", msr_o, 8'h40);
    ri = 0; repeat (6) tick();
    chk("teri", msr_o, 8'h04);
    dsr = 1; repeat (5) tick();
    rd = 1; tick(); rd = 0;
    chk("ddsr_wins", msr_o, 8'h22);

    // Auto-RTS hysteresis
    do_reset();
    mcr = 5'b00010; afe = 1;
    lvl = 13; tick(); chk("rts_13", 8'(rts_o), 8'h01);
    lvl = 14; tick(); chk("rts_14", 8'(rts_o), 8'h00);
    lvl = 10; tick(); chk("rts_10", 8'(rts_o), 8'h00);
    lvl = 8;  tick(); chk("rts_8",  8'(rts_o), 8'h01);
    lvl = 9;  tick(); chk("rts_9",  8'(rts_o), 8'h01);
    lvl = 15; tick(); chk("rts_15", 8'(rts_o), 8'h00);
    afe = 0;  tick(); chk("rts_noafe", 8'(rts_o), 8'h01);

    // TX gating on filtered CTS
    do_reset();
    afe = 1; req = 1;
    repeat (4) begin tick(); chk("gnt_blocked", 8'(gnt_o), 8'h00); end
    cts = 1;
    repeat (6) begin tick(); chk("gnt_wait", 8'(gnt_o), 8'h00); end
    tick(); chk("gnt_cts", 8'(gnt_o), 8'h01);
    req = 0; tick(); chk("gnt_pulse", 8'(gnt_o), 8'h00);
    cts = 0; repeat (6) tick();
    chk("cts_low", 8'(msr_o[4]), 8'h00);
    afe = 0; req = 1; tick(); chk("gnt_noafe", 8'(gnt_o), 8'h01);
    req = 0; tick();

    // Loopback then asynchronous reset mid-sequence
    do_reset();
    mcr = 5'h1F;
    repeat (3) begin
      tick();
      chk("loop_msr", msr_o, 8'h00);
      chk("loop_pads", {6'b0, rts_o, dtr_o}, 8'h00);
    end
    tick();
    chk("loop_msr4", msr_o, 8'hFB);
    ier = 1; tick();
    mid_reset();

    // Randomized run against the model
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) cts = ~cts;
      if ($urandom_range(0, 7) == 0) dsr = ~dsr;
      if ($urandom_range(0, 7) == 0) ri  = ~ri;
      if ($urandom_range(0, 7) == 0) dcd = ~dcd;
      if ($urandom_range(0, 31) == 0) mcr[3:0] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) mcr[4] = ~mcr[4];
      if ($urandom_range(0, 31) == 0) afe = ~afe;
      if ($urandom_range(0, 31) == 0) ier = ~ier;
      rd  = ($urandom_range(0, 7) == 0);
      req = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) lvl = 5'($urandom_range(0, 16));
      else if ($urandom_range(0, 1) == 1) begin
        if (lvl < 16) lvl = lvl + 1;
      end else if (lvl > 0) lvl = lvl - 1;
      tick();
      if (c % 700 == 699) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
